// File: rtl/intc_sched.sv
// Interrupt sequencer: captures accelerator done edges, arbitrates, runs IRQ/IACK/EOI.
// Define INTC_RR_EN for round-robin arbitration; fixed priority (source 0 first) otherwise.
module intc_sched #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7000,
   parameter logic [31:0] VEC0_RST  = 32'h0003_0000,
   parameter logic [31:0] VEC1_RST  = 32'h0004_0000,
   parameter logic [31:0] VEC2_RST  = 32'h0005_0000,
   parameter logic [31:0] VEC3_RST  = 32'h0006_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  done,
   input  logic        IACK,
   input  logic [31:0] input_addr,
   input  logic        write_enable,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        IRQ,
   output logic [31:0] isr_addr,
   output logic        in_service
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] vec_q [4];
   logic [31:0] vec_d [4];
   logic [3:0]  mask_q, mask_d;
   logic [3:0]  pend_q, pend_d;
   logic [3:0]  done_prev_q, done_prev_d;
   logic [1:0]  grant_q, grant_d;
   logic        irq_q, irq_d;
   logic        in_service_q, in_service_d;
   logic [31:0] isr_addr_q, isr_addr_d;

   logic        in_window;
   logic [2:0]  reg_idx;
   logic        wr_mask, wr_pend, wr_eoi;
   logic [3:0]  wr_vec;
   logic [3:0]  rise;
   logic [3:0]  w1c_bits;
   logic [3:0]  clr_iack;
   logic [3:0]  cand;
   logic        cand_any;
   logic [1:0]  cand_id;

   // Word-aligned accesses inside the 32-byte window only.
   assign in_window = (input_addr[31:5] == BASE_ADDR[31:5]) && (input_addr[1:0] == 2'b00);
   assign reg_idx   = input_addr[4:2];

   always_comb begin
      wr_vec  = '0;
      wr_mask = 1'b0;
      wr_pend = 1'b0;
      wr_eoi  = 1'b0;
      if (write_enable && in_window) begin
         case (reg_idx)
            3'd0, 3'd1, 3'd2, 3'd3: wr_vec[reg_idx[1:0]] = 1'b1;
            3'd4:    wr_mask = 1'b1;
            3'd5:    wr_pend = 1'b1;
            3'd6:    wr_eoi  = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      read_data = '0;
      if (in_window) begin
         case (reg_idx)
            3'd0, 3'd1, 3'd2, 3'd3: read_data = vec_q[reg_idx[1:0]];
            3'd4:    read_data = {28'd0, mask_q};
            3'd5:    read_data = {28'd0, pend_q};
            3'd7:    read_data = {28'd0, irq_q, grant_q, in_service_q};
            default: read_data = '0;
         endcase
      end
   end

   assign rise     = done & ~done_prev_q;
   assign w1c_bits = wr_pend ? write_data[3:0] : 4'd0;
   assign cand     = pend_q & mask_q;
   assign cand_any = |cand;

`ifdef INTC_RR_EN
   logic [1:0] last_q, last_d;
   logic [1:0] rr_idx;

   // Walk the search order backwards so the earliest hit after last_q wins.
   always_comb begin
      cand_id = 2'd0;
      rr_idx  = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         rr_idx = last_q + 2'd1 + 2'(k);
         if (cand[rr_idx]) cand_id = rr_idx;
      end
   end

   always_comb begin
      last_d = last_q;
      if (state_q == ST_IDLE && cand_any) last_d = cand_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 2'd3;
      else        last_q <= last_d;
   end
`else
   always_comb begin
      cand_id = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (cand[i]) cand_id = 2'(i);
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      irq_d        = irq_q;
      in_service_d = in_service_q;
      isr_addr_d   = isr_addr_q;
      clr_iack     = '0;
      case (state_q)
         ST_IDLE: begin
            if (cand_any) begin
               grant_d    = cand_id;
               isr_addr_d = vec_q[cand_id];
               irq_d      = 1'b1;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            // Software withdrew the granted source before the CPU acknowledged.
            if (!(pend_q[grant_q] && mask_q[grant_q])) begin
               irq_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (IACK) begin
               irq_d             = 1'b0;
               in_service_d      = 1'b1;
               clr_iack[grant_q] = 1'b1;
               state_d           = ST_SVC;
            end
         end
         ST_SVC: begin
            if (wr_eoi) begin
               in_service_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new edge wins over both the IACK clear and a W1C of the same bit.
   always_comb begin
      pend_d      = (pend_q & ~w1c_bits & ~clr_iack) | rise;
      mask_d      = wr_mask ? write_data[3:0] : mask_q;
      done_prev_d = done;
      for (int i = 0; i < 4; i++) begin
         vec_d[i] = wr_vec[i] ? write_data : vec_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         vec_q[0]     <= VEC0_RST;
         vec_q[1]     <= VEC1_RST;
         vec_q[2]     <= VEC2_RST;
         vec_q[3]     <= VEC3_RST;
         mask_q       <= 4'hF;
         pend_q       <= 4'h0;
         done_prev_q  <= 4'h0;
         grant_q      <= 2'd0;
         irq_q        <= 1'b0;
         in_service_q <= 1'b0;
         isr_addr_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         vec_q[0]     <= vec_d[0];
         vec_q[1]     <= vec_d[1];
         vec_q[2]     <= vec_d[2];
         vec_q[3]     <= vec_d[3];
         mask_q       <= mask_d;
         pend_q       <= pend_d;
         done_prev_q  <= done_prev_d;
         grant_q      <= grant_d;
         irq_q        <= irq_d;
         in_service_q <= in_service_d;
         isr_addr_q   <= isr_addr_d;
      end
   end

   assign IRQ        = irq_q;
   assign isr_addr   = isr_addr_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_intc_sched.sv
// Directed bench for intc_sched: register map, grant/IACK/EOI sequencing, edge capture, arbitration.
module tb_intc_sched;

   localparam logic [31:0] BASE = 32'h0000_7000;
   localparam logic [31:0] O_VEC0 = 32'h00, O_VEC1 = 32'h04, O_VEC2 = 32'h08, O_VEC3 = 32'h0C;
   localparam logic [31:0] O_MASK = 32'h10, O_PEND = 32'h14, O_EOI = 32'h18, O_STAT = 32'h1C;

   logic        clk;
   logic        rst_n;
   logic [3:0]  done;
   logic        IACK;
   logic [31:0] input_addr;
   logic        write_enable;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        IRQ;
   logic [31:0] isr_addr;
   logic        in_service;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [1:0] exp_q[$];

   intc_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .done         (done),
      .IACK         (IACK),
      .input_addr   (input_addr),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_data    (read_data),
      .IRQ          (IRQ),
      .isr_addr     (isr_addr),
      .in_service   (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      done         = 4'd0;
      IACK         = 1'b0;
      input_addr   = 32'd0;
      write_enable = 1'b0;
      write_data   = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      input_addr   = a;
      write_data   = d;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      input_addr   = 32'd0;
   endtask

   task automatic rd_raw(input logic [31:0] a, output logic [31:0] d);
      input_addr = a;
      #1;
      d = read_data;
      input_addr = 32'd0;
   endtask

   task automatic chk_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
      logic [31:0] d;
      rd_raw(BASE + off, d);
      check(tag, d, exp);
   endtask

   task automatic pulse_iack();
      IACK = 1'b1;
      tick();
      IACK = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  g;

      // Reset values and register map
      do_reset();
      check("rst_irq", {31'd0, IRQ}, 32'd0);
      check("rst_insvc", {31'd0, in_service}, 32'd0);
      check("rst_isr", isr_addr, 32'd0);
      chk_reg("rst_vec0", O_VEC0, 32'h0003_0000);
      chk_reg("rst_vec1", O_VEC1, 32'h0004_0000);
      chk_reg("rst_vec2", O_VEC2, 32'h0005_0000);
      chk_reg("rst_vec3", O_VEC3, 32'h0006_0000);
      chk_reg("rst_mask", O_MASK, 32'h0000_000F);
      chk_reg("rst_pend", O_PEND, 32'd0);
      chk_reg("rst_stat", O_STAT, 32'd0);
      chk_reg("eoi_reads_0", O_EOI, 32'd0);
      rd_raw(BASE + 32'h20, d);
      check("outside_reads_0", d, 32'd0);
      bus_write(32'h0000_8000, 32'hDEAD_BEEF);
      chk_reg("outside_wr_ignored", O_VEC0, 32'h0003_0000);
      bus_write(BASE + O_STAT, 32'hFFFF_FFFF);
      chk_reg("stat_ro", O_STAT, 32'd0);

      // Single source: done[2]
      done = 4'b0100;
      tick();
      done = 4'b0000;
      check("d2_irq_lat", {31'd0, IRQ}, 32'd0);
      chk_reg("d2_pend", O_PEND, 32'h4);
      tick();
      check("d2_irq", {31'd0, IRQ}, 32'd1);
      check("d2_isr", isr_addr, 32'h0005_0000);
      chk_reg("d2_stat_req", O_STAT, 32'hC);
      pulse_iack();
      check("d2_iack_irq", {31'd0, IRQ}, 32'd0);
      check("d2_iack_insvc", {31'd0, in_service}, 32'd1);
      chk_reg("d2_iack_pend", O_PEND, 32'd0);
      chk_reg("d2_stat_svc", O_STAT, 32'h5);
      bus_write(BASE + O_EOI, 32'd0);
      check("d2_eoi_insvc", {31'd0, in_service}, 32'd0);
      check("d2_isr_held", isr_addr, 32'h0005_0000);

      // Priority between sources 3 and 1; grant frozen while requesting
      do_reset();
      done = 4'b1010;
      tick();
      done = 4'b0000;
      tick();
      check("p31_irq", {31'd0, IRQ}, 32'd1);
      check("p31_isr1", isr_addr, 32'h0004_0000);
      chk_reg("p31_stat1", O_STAT, 32'hA);
      pulse_iack();
      chk_reg("p31_pend_after1", O_PEND, 32'h8);
      bus_write(BASE + O_EOI, 32'd0);
      tick();
      check("p31_irq3", {31'd0, IRQ}, 32'd1);
      check("p31_isr3", isr_addr, 32'h0006_0000);
      done = 4'b0001;
      tick();
      done = 4'b0000;
      check("freeze_isr", isr_addr, 32'h0006_0000);
      chk_reg("freeze_stat", O_STAT, 32'hE);
      pulse_iack();
      bus_write(BASE + O_EOI, 32'd0);
      tick();
      check("after_freeze_isr0", isr_addr, 32'h0003_0000);
      pulse_iack();
      bus_write(BASE + O_EOI, 32'd0);

      // Masking: held off while masked, fires on unmask, cancels on mask/W1C in REQ
      bus_write(BASE + O_MASK, 32'hE);
      done = 4'b0001;
      tick();
      done = 4'b0000;
      tick();
      tick();
      check("masked_no_irq", {31'd0, IRQ}, 32'd0);
      chk_reg("masked_pend", O_PEND, 32'h1);
      bus_write(BASE + O_MASK, 32'hF);
      check("unmask_irq_lat", {31'd0, IRQ}, 32'd0);
      tick();
      check("unmask_irq", {31'd0, IRQ}, 32'd1);
      check("unmask_isr", isr_addr, 32'h0003_0000);
      bus_write(BASE + O_MASK, 32'hE);
      tick();
      check("mask_cancel_irq", {31'd0, IRQ}, 32'd0);
      chk_reg("mask_cancel_pend", O_PEND, 32'h1);
      bus_write(BASE + O_MASK, 32'hF);
      tick();
      check("remask_irq", {31'd0, IRQ}, 32'd1);
      bus_write(BASE + O_PEND, 32'h1);
      tick();
      check("w1c_cancel_irq", {31'd0, IRQ}, 32'd0);
      chk_reg("w1c_cancel_pend", O_PEND, 32'd0);
      pulse_iack();
      check("iack_idle_ignored", {31'd0, in_service}, 32'd0);

      // Vector rewrite, level-held done, vector write during service
      bus_write(BASE + O_VEC1, 32'h0008_0000);
      chk_reg("vec1_rw", O_VEC1, 32'h0008_0000);
      done = 4'b0010;
      tick();
      tick();
      check("vec1_isr", isr_addr, 32'h0008_0000);
      pulse_iack();
      repeat (7) tick();
      chk_reg("level_no_repend", O_PEND, 32'd0);
      bus_write(BASE + O_VEC1, 32'h0009_0000);
      check("vec_wr_svc_isr", isr_addr, 32'h0008_0000);
      done = 4'b0000;
      bus_write(BASE + O_EOI, 32'd0);
      tick();
      check("level_single_evt", {31'd0, IRQ}, 32'd0);

      // Set wins over IACK clear and over W1C of the same bit
      done = 4'b0100;
      tick();
      done = 4'b0000;
      tick();
      IACK = 1'b1;
      done = 4'b0100;
      tick();
      IACK = 1'b0;
      done = 4'b0000;
      chk_reg("set_vs_iack_pend", O_PEND, 32'h4);
      check("set_vs_iack_insvc", {31'd0, in_service}, 32'd1);
      bus_write(BASE + O_EOI, 32'd0);
      tick();
      check("set_vs_iack_regrant", isr_addr, 32'h0005_0000);
      pulse_iack();
      bus_write(BASE + O_EOI, 32'd0);
      bus_write(BASE + O_MASK, 32'h7);
      done = 4'b1000;
      tick();
      done = 4'b0000;
      tick();
      chk_reg("d3_masked_pend", O_PEND, 32'h8);
      done = 4'b1000;
      bus_write(BASE + O_PEND, 32'h8);
      done = 4'b0000;
      chk_reg("set_vs_w1c_pend", O_PEND, 32'h8);
      bus_write(BASE + O_PEND, 32'h8);
      chk_reg("w1c_clears", O_PEND, 32'd0);
      bus_write(BASE + O_MASK, 32'hF);
      tick();
      check("w1c_no_irq", {31'd0, IRQ}, 32'd0);

      // Arbitration policy with sources 0 and 1 re-pulsed during every service
      for (int r = 0; r < 4; r++) begin
`ifdef INTC_RR_EN
         exp_q.push_back(2'(r % 2));
`else
         exp_q.push_back(2'd0);
`endif
      end
      done = 4'b0011;
      tick();
      done = 4'b0000;
      tick();
      for (int r = 0; r < 4; r++) begin
         g = exp_q.pop_front();
         check("arb_irq", {31'd0, IRQ}, 32'd1);
         rd_raw(BASE + O_STAT, d);
         check("arb_grant", {30'd0, d[2:1]}, {30'd0, g});
         pulse_iack();
         done = 4'b0011;
         tick();
         done = 4'b0000;
         tick();
         bus_write(BASE + O_EOI, 32'd0);
         tick();
      end

      // Asynchronous reset while requesting
      check("pre_areset_irq", {31'd0, IRQ}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_irq", {31'd0, IRQ}, 32'd0);
      check("areset_isr", isr_addr, 32'd0);
      chk_reg("areset_pend", O_PEND, 32'd0);
      chk_reg("areset_vec1", O_VEC1, 32'h0004_0000);
      chk_reg("areset_stat", O_STAT, 32'd0);
      tick();
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
